pipe_stage_register: RTL and testbench
======================================

PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 Parameter DATA_W, default 128: width of the datapath payload (operand values, PC, immediates, register tags).
REQ-002 Parameter CTRL_W, default 8: width of the control payload (write-back, memory, branch and status-update enables).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  synchronous squash of all held entries.
REQ-006 in_valid  input  1  upstream offers a beat.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_ctrl  input  CTRL_W  control payload of the offered beat.
REQ-009 in_data  input  DATA_W  datapath payload of the offered beat.
REQ-010 out_valid  output  1  stage presents a beat downstream.
REQ-011 out_ready  input  1  downstream accepts the presented beat.
REQ-012 out_ctrl  output  CTRL_W  control payload; all zeros whenever out_valid=0.
REQ-013 out_data  output  DATA_W  datapath payload of the presented beat.

Function
REQ-014 An input transfer SHALL occur when in_valid=1 and in_ready=1; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-015 A beat accepted in cycle N SHALL appear on out_* in cycle N+1 when the stage was empty or drained in cycle N (latency 1).
REQ-016 Storage SHALL be a main entry driving out_* plus a skid entry; state is EMPTY, FULL (main only) or SKID (main and skid).
REQ-017 EMPTY: on an input transfer go to FULL; otherwise stay.
REQ-018 FULL: input and output transfer together -> load main, stay FULL; output only -> EMPTY; input only -> capture into skid, go to SKID; neither -> stay.
REQ-019 SKID: on an output transfer, move skid to main and go to FULL; otherwise stay; in_ready=0 in SKID.
REQ-020 Beats SHALL leave in acceptance order with no loss or duplication.
REQ-021 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 SHALL set the state to EMPTY next cycle, discard the main and skid entries, and drop any beat offered the same cycle regardless of in_ready.
REQ-023 flush SHALL take priority over simultaneous input and output transfers; an out_ready handshake in the flush cycle still counts as consumed downstream.
REQ-024 While out_valid=0, out_ctrl SHALL be zero, so an empty or flushed stage injects a bubble.
REQ-025 rst SHALL take priority over flush and all handshakes.

Reset
REQ-026 On rst, the state SHALL be EMPTY: out_valid=0, out_ctrl=0, out_data=0, skid entry cleared.
REQ-027 in_ready SHALL be 1 in the cycle after reset is released.
REQ-028 Reset asserted mid-transfer SHALL discard all held beats without emitting them.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: the skid entry and SKID state are present, and in_ready SHALL be registered, equal to (state != SKID), with no combinational path from out_ready.
REQ-030 PIPE_STAGE_SKID_EN undefined: no skid entry, and states are EMPTY/FULL only.
REQ-031 PIPE_STAGE_SKID_EN undefined: in_ready SHALL be the combinational value (out_valid=0 or out_ready=1).
REQ-032 PIPE_STAGE_SKID_EN undefined: FULL with an input transfer and no output transfer SHALL be unreachable.
REQ-033 Port list, latency and flush/reset behaviour SHALL be identical in both builds.

Verification
REQ-034 Streaming: in_valid=1 with data 0x1,0x2,0x3 and out_ready=1 constantly -> out_data 0x1,0x2,0x3 on consecutive cycles one cycle later; in_ready=1 throughout.
REQ-035 Backpressure (skid build): out_ready=0 while offering 0xA then 0xB -> 0xA held on out_data, 0xB in skid, in_ready=0; after out_ready=1, output is 0xA then 0xB.
REQ-036 Flush: stage in SKID holding 0xA,0xB, flush=1 with in_valid=1 and data 0xC -> next cycle out_valid=0, out_ctrl=0, and 0xA, 0xB, 0xC are never emitted.
REQ-037 Reset mid-operation: FULL with in_ctrl=0xFF beat held, rst=1 for one cycle -> out_valid=0, out_ctrl=0x00, out_data=0; in_ready=1 the next cycle.
REQ-038 Random valid/ready toggling, 1000 beats with an incrementing counter payload, both builds -> scoreboard shows in-order delivery with no loss or duplication, and out_data stable under stall.

Source files
------------

// File: rtl/pipe_stage_register.sv
// Pipeline stage register with a valid/ready handshake, bubble-injecting flush and sync reset.
// Define PIPE_STAGE_SKID_EN to add a skid entry so that in_ready becomes a register.
module pipe_stage_register #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e            state_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] main_data_q;
   logic              in_xfer;
   logic              out_xfer;

   // Gating out_ctrl turns any empty or flushed cycle into a bubble downstream.
   assign out_valid = (state_q != EMPTY);
   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign out_data  = main_data_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              ready_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;

   assign in_ready = ready_q;

   // NOTE: state is updated with non-blocking assignments only, so every branch
   // below reads the values from before this edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         ready_q     <= 1'b1;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
                  state_q     <= FULL;
               end
            end
            FULL: begin
               if (in_xfer && out_xfer) begin
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
               end else if (out_xfer) begin
                  state_q <= EMPTY;
               end else if (in_xfer) begin
                  skid_ctrl_q <= in_ctrl;
                  skid_data_q <= in_data;
                  state_q     <= SKID;
                  ready_q     <= 1'b0;
               end
            end
            SKID: begin
               if (out_xfer) begin
                  main_ctrl_q <= skid_ctrl_q;
                  main_data_q <= skid_data_q;
                  state_q     <= FULL;
                  ready_q     <= 1'b1;
               end
            end
            default: begin
               state_q <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
`else
   // Without a skid entry, a full stage may only accept when its beat leaves this cycle.
   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
                  state_q     <= FULL;
               end
            end
            FULL: begin
               if (in_xfer) begin
                  main_ctrl_q <= in_ctrl;
                  main_data_q <= in_data;
               end else if (out_xfer) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed and randomized handshake bench for pipe_stage_register (either build of PIPE_STAGE_SKID_EN).
module tb_pipe_stage_register;
   localparam int DATA_W = 128;
   localparam int CTRL_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_register #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++;
      if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_out_ctrl got %0h exp 0", out_ctrl); end
      checks++;
      if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_streaming();
      logic [DATA_W-1:0] exp_d;
      logic [CTRL_W-1:0] exp_c;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         exp_d   = DATA_W'(k);
         exp_c   = CTRL_W'(8'h10 + k);
         in_data = exp_d;
         in_ctrl = exp_c;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d got %b exp 1", k, in_ready); end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d || out_ctrl !== exp_c) begin
            errors++;
            $display("FAIL stream_out beat %0d got v=%b d=%0h c=%0h exp v=1 d=%0h c=%0h",
                     k, out_valid, out_data, out_ctrl, exp_d, exp_c);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL stream_drain got v=%b c=%0h exp v=0 c=0", out_valid, out_ctrl);
      end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      in_valid = 1'b1;
      in_data  = 128'hA;
      in_ctrl  = 8'h0A;
      tick();
      in_data = 128'hB;
      in_ctrl = 8'h0B;
      #1;
      checks++;
`ifdef PIPE_STAGE_SKID_EN
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_full got %b exp 1", in_ready); end
`else
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
`endif
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stalled got %b exp 0", in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'hA || out_ctrl !== 8'h0A) begin
         errors++;
         $display("FAIL bp_hold got v=%b d=%0h c=%0h exp v=1 d=a c=a", out_valid, out_data, out_ctrl);
      end
      out_ready = 1'b1;
      tick();
`ifdef PIPE_STAGE_SKID_EN
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'hB || out_ctrl !== 8'h0B) begin
         errors++;
         $display("FAIL bp_second got v=%b d=%0h c=%0h exp v=1 d=b c=b", out_valid, out_data, out_ctrl);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", in_ready); end
      tick();
`endif
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL bp_drain got v=%b c=%0h exp v=0 c=0", out_valid, out_ctrl);
      end
   endtask

   task automatic test_flush();
      idle_inputs();
      in_valid = 1'b1;
      in_data  = 128'hA;
      in_ctrl  = 8'h0A;
      tick();
      in_data = 128'hB;
      in_ctrl = 8'h0B;
      tick();
      flush   = 1'b1;
      in_data = 128'hC;
      in_ctrl = 8'h0C;
      tick();
      idle_inputs();
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL flush_bubble got v=%b c=%0h exp v=0 c=0", out_valid, out_ctrl);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_emit cycle %0d got v=%b d=%0h exp v=0", k, out_valid, out_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      in_valid = 1'b1;
      in_ctrl  = 8'hFF;
      in_data  = 128'h55;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 8'hFF) begin
         errors++;
         $display("FAIL rstmid_full got v=%b c=%0h exp v=1 c=ff", out_valid, out_ctrl);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 128'h0) begin
         errors++;
         $display("FAIL rstmid_clear got v=%b c=%0h d=%0h exp v=0 c=0 d=0", out_valid, out_ctrl, out_data);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] sb_q[$];
      logic [DATA_W-1:0] prev_data;
      logic              prev_stall;
      int                sent;
      int                got;
      int                cyc;
      sent       = 0;
      got        = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      idle_inputs();
      while (got < 1000 && cyc < 20000) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = DATA_W'(sent);
         in_ctrl   = sent[CTRL_W-1:0];
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) begin
            checks++;
            errors++;
            $display("FAIL rand_stable cycle %0d got v=%b d=%0h exp v=1 d=%0h", cyc, out_valid, out_data, prev_data);
         end else if (prev_stall) begin
            checks++;
         end
         if (!out_valid) begin
            checks++;
            if (out_ctrl !== 8'h00) begin errors++; $display("FAIL rand_bubble_ctrl got %0h exp 0", out_ctrl); end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL rand_order unexpected beat d=%0h exp none", out_data);
            end else begin
               if (out_data !== sb_q[0] || out_ctrl !== sb_q[0][CTRL_W-1:0]) begin
                  errors++;
                  $display("FAIL rand_order got d=%0h c=%0h exp d=%0h", out_data, out_ctrl, sb_q[0]);
               end
               void'(sb_q.pop_front());
            end
            got++;
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         tick();
         cyc++;
      end
      idle_inputs();
      checks++;
      if (got != 1000) begin errors++; $display("FAIL rand_count got %0d exp 1000", got); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", sb_q.size()); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
